// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing definitions for the VGA sync generator.
//   - DEF_* constants: default 640x480@60 active/porch/sync values
//   - H_TOTAL / V_TOTAL: derived line and frame lengths (800 / 525)
//   - CNT_W / coord_t: width and type of the posx/posy counters
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int CNT_W = 11;

  typedef logic [CNT_W-1:0] coord_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if
//   Bundle between the sync generator and the display pipeline.
//   Signals:
//     pix_en      pixel tick enable from the clock divider
//     posx/posy   current pixel coordinates
//     hsync/vsync active-low sync pulses
//     video_on    visible-area qualifier
//     line_start  one-clk strobe when posx becomes 0
//     frame_start one-clk strobe when (posx,posy) becomes (0,0)
//   Modports:
//     master  the sync generator (consumes pix_en, drives timing)
//     slave   the surrounding display logic (supplies pix_en, consumes timing)
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   pix_en;
  coord_t posx;
  coord_t posy;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   line_start;
  logic   frame_start;

  modport master (
    input  pix_en,
    output posx, posy, hsync, vsync, video_on, line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  posx, posy, hsync, vsync, video_on, line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One axis (horizontal or vertical) of the VGA timing: a wrap counter
//   with enable plus sync-window and active-window decode.
//   Ports:
//     clk, reset  clock and synchronous active-high reset
//     en          advance the counter this clk
//     cnt         registered position, 0..TOTAL-1 (resets to TOTAL-1)
//     wrap        cnt is at TOTAL-1 (next advance wraps to 0)
//     sync_n      registered active-low sync, aligned with cnt
//     active_nxt  combinational: next position lies in the active window
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL,
  parameter int ACTIVE     = DEF_H_ACTIVE,
  parameter int SYNC_START = DEF_H_ACTIVE + DEF_H_FP,
  parameter int SYNC_LEN   = DEF_H_SYNC
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  output coord_t cnt,
  output logic   wrap,
  output logic   sync_n,
  output logic   active_nxt
);

  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam coord_t ACT_END = coord_t'(ACTIVE);
  localparam coord_t SYNC_LO = coord_t'(SYNC_START);
  localparam coord_t SYNC_HI = coord_t'(SYNC_START + SYNC_LEN - 1);

  coord_t cnt_nxt;

  assign wrap = (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (en) begin
      cnt_nxt = wrap ? '0 : cnt + 1'b1;
    end
  end

  // Decoding from cnt_nxt keeps the registered sync aligned with cnt.
  assign active_nxt = (cnt_nxt < ACT_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= LAST;
      sync_n <= 1'b1;
    end else begin
      cnt    <= cnt_nxt;
      sync_n <= !((cnt_nxt >= SYNC_LO) && (cnt_nxt <= SYNC_HI));
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   VGA pixel-coordinate and sync generator (default 640x480@60, 800x525).
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high; loads the back-porch position
//            (799,524) so the first tick lands on (0,0)
//     vga    vga_sync_gen_if.master: pix_en in; posx, posy, hsync, vsync,
//            video_on, line_start, frame_start out (all registered)
//   Build option:
//     VGA_PIX_DIV2_EN  when defined, an internal toggle flop supplies a tick
//                      every 2nd clk and pix_en is ignored; otherwise the
//                      tick is pix_en.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input logic            clk,
  input logic            reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOT - 1) >= (2 ** CNT_W) || (V_TOT - 1) >= (2 ** CNT_W)) begin : g_width_chk
    $error("CNT_W too narrow for the configured timing");
  end

  logic tick;

`ifdef VGA_PIX_DIV2_EN
  logic toggle;

  always_ff @(posedge clk) begin
    if (reset) begin
      toggle <= 1'b0;
    end else begin
      toggle <= ~toggle;
    end
  end

  assign tick = toggle;
`else
  assign tick = vga.pix_en;
`endif

  coord_t h_cnt, v_cnt;
  logic   h_wrap, v_wrap;
  logic   h_sync_n, v_sync_n;
  logic   h_act_nxt, v_act_nxt;
  logic   v_en;

  assign v_en = tick & h_wrap;

  vga_axis_counter #(
    .TOTAL      (H_TOT),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC)
  ) u_h (
    .clk        (clk),
    .reset      (reset),
    .en         (tick),
    .cnt        (h_cnt),
    .wrap       (h_wrap),
    .sync_n     (h_sync_n),
    .active_nxt (h_act_nxt)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOT),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC)
  ) u_v (
    .clk        (clk),
    .reset      (reset),
    .en         (v_en),
    .cnt        (v_cnt),
    .wrap       (v_wrap),
    .sync_n     (v_sync_n),
    .active_nxt (v_act_nxt)
  );

  logic video_on_r;
  logic line_start_r;
  logic frame_start_r;

  // Strobes are set only on the wrapping tick and self-clear on the next clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      video_on_r    <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      video_on_r    <= h_act_nxt & v_act_nxt;
      line_start_r  <= tick & h_wrap;
      frame_start_r <= tick & h_wrap & v_wrap;
    end
  end

  assign vga.posx        = h_cnt;
  assign vga.posy        = v_cnt;
  assign vga.hsync       = h_sync_n;
  assign vga.vsync       = v_sync_n;
  assign vga.video_on    = video_on_r;
  assign vga.line_start  = line_start_r;
  assign vga.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   Directed bench for vga_sync_gen. dut_m uses the default 640x480 timing;
//   dut_s uses a reduced timing (32x19 total) so vertical sync and a full
//   frame wrap fit in a short run. Observed outputs are packed as
//   {posx, posy, hsync, vsync, video_on, line_start, frame_start}.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset;
  logic reset_s;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if vga_m ();
  vga_sync_gen_if vga_s ();

  vga_sync_gen dut_m (
    .clk   (clk),
    .reset (reset),
    .vga   (vga_m.master)
  );

  // Small timing: H 16/4/8/4 (hsync 20..27), V 12/2/2/3 (vsync 14..15).
  vga_sync_gen #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (3)
  ) dut_s (
    .clk   (clk),
    .reset (reset_s),
    .vga   (vga_s.master)
  );

  wire [26:0] obs_m = {vga_m.posx, vga_m.posy, vga_m.hsync, vga_m.vsync,
                       vga_m.video_on, vga_m.line_start, vga_m.frame_start};
  wire [26:0] obs_s = {vga_s.posx, vga_s.posy, vga_s.hsync, vga_s.vsync,
                       vga_s.video_on, vga_s.line_start, vga_s.frame_start};

  task automatic test_reset();
    logic [26:0] exp;
    reset = 1'b1;
    vga_m.pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp = {11'd799, 11'd524, 5'b11000};
    checks++;
    if (obs_m !== exp) begin
      errors++;
      $display("FAIL reset_state: got x=%0d y=%0d hs/vs/on/ls/fs=%b, expected x=%0d y=%0d hs/vs/on/ls/fs=%b",
               obs_m[26:16], obs_m[15:5], obs_m[4:0], exp[26:16], exp[15:5], exp[4:0]);
    end
  endtask

`ifndef VGA_PIX_DIV2_EN
  task automatic test_first_tick();
    logic [26:0] exp;
    reset = 1'b0;
    vga_m.pix_en = 1'b1;
    @(posedge clk);
    #1;
    exp = {11'd0, 11'd0, 5'b11111};
    checks++;
    if (obs_m !== exp) begin
      errors++;
      $display("FAIL first_tick: got x=%0d y=%0d hs/vs/on/ls/fs=%b, expected x=%0d y=%0d hs/vs/on/ls/fs=%b",
               obs_m[26:16], obs_m[15:5], obs_m[4:0], exp[26:16], exp[15:5], exp[4:0]);
    end
    vga_m.pix_en = 1'b0;
    @(posedge clk);
    #1;
    exp = {11'd0, 11'd0, 5'b11100};
    checks++;
    if (obs_m !== exp) begin
      errors++;
      $display("FAIL strobe_clear: got x=%0d y=%0d hs/vs/on/ls/fs=%b, expected x=%0d y=%0d hs/vs/on/ls/fs=%b",
               obs_m[26:16], obs_m[15:5], obs_m[4:0], exp[26:16], exp[15:5], exp[4:0]);
    end
  endtask

  // Starts at (0,0); each row advances with pix_en high then compares.
  task automatic test_hsync();
    int          steps [6] = '{639, 1, 15, 1, 95, 1};
    logic [26:0] expv  [6] = '{{11'd639, 11'd0, 5'b11100},
                               {11'd640, 11'd0, 5'b11000},
                               {11'd655, 11'd0, 5'b11000},
                               {11'd656, 11'd0, 5'b01000},
                               {11'd751, 11'd0, 5'b01000},
                               {11'd752, 11'd0, 5'b11000}};
    for (int i = 0; i < 6; i++) begin
      vga_m.pix_en = 1'b1;
      repeat (steps[i]) @(posedge clk);
      #1;
      checks++;
      if (obs_m !== expv[i]) begin
        errors++;
        $display("FAIL hsync_row%0d: got x=%0d y=%0d hs/vs/on/ls/fs=%b, expected x=%0d y=%0d hs/vs/on/ls/fs=%b",
                 i, obs_m[26:16], obs_m[15:5], obs_m[4:0], expv[i][26:16], expv[i][15:5], expv[i][4:0]);
      end
    end
  endtask

  // Continues from (752,0).
  task automatic test_line_wrap();
    int          steps [4] = '{47, 8000, 1, 1};
    logic [26:0] expv  [4] = '{{11'd799, 11'd0,  5'b11000},
                               {11'd799, 11'd10, 5'b11000},
                               {11'd0,   11'd11, 5'b11110},
                               {11'd1,   11'd11, 5'b11100}};
    for (int i = 0; i < 4; i++) begin
      vga_m.pix_en = 1'b1;
      repeat (steps[i]) @(posedge clk);
      #1;
      checks++;
      if (obs_m !== expv[i]) begin
        errors++;
        $display("FAIL line_wrap_row%0d: got x=%0d y=%0d hs/vs/on/ls/fs=%b, expected x=%0d y=%0d hs/vs/on/ls/fs=%b",
                 i, obs_m[26:16], obs_m[15:5], obs_m[4:0], expv[i][26:16], expv[i][15:5], expv[i][4:0]);
      end
    end
  endtask

  // Continues from (1,11): move to (300,11), then hold pix_en low.
  task automatic test_freeze();
    logic [26:0] exp;
    exp = {11'd300, 11'd11, 5'b11100};
    vga_m.pix_en = 1'b1;
    repeat (299) @(posedge clk);
    #1;
    vga_m.pix_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs_m !== exp) begin
        errors++;
        $display("FAIL freeze_clk%0d: got x=%0d y=%0d hs/vs/on/ls/fs=%b, expected x=%0d y=%0d hs/vs/on/ls/fs=%b",
                 i, obs_m[26:16], obs_m[15:5], obs_m[4:0], exp[26:16], exp[15:5], exp[4:0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [26:0] exp;
    reset = 1'b1;
    vga_m.pix_en = 1'b1;
    @(posedge clk);
    #1;
    exp = {11'd799, 11'd524, 5'b11000};
    checks++;
    if (obs_m !== exp) begin
      errors++;
      $display("FAIL reset_mid_frame: got x=%0d y=%0d hs/vs/on/ls/fs=%b, expected x=%0d y=%0d hs/vs/on/ls/fs=%b",
               obs_m[26:16], obs_m[15:5], obs_m[4:0], exp[26:16], exp[15:5], exp[4:0]);
    end
    reset = 1'b0;
    vga_m.pix_en = 1'b0;
  endtask

  task automatic test_vsync_small();
    int          steps [6] = '{1, 447, 1, 63, 1, 96};
    logic [26:0] expv  [6] = '{{11'd0,  11'd0,  5'b11111},
                               {11'd31, 11'd13, 5'b11000},
                               {11'd0,  11'd14, 5'b10010},
                               {11'd31, 11'd15, 5'b10000},
                               {11'd0,  11'd16, 5'b11010},
                               {11'd0,  11'd0,  5'b11111}};
    reset_s = 1'b1;
    vga_s.pix_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vga_s.pix_en = 1'b1;
      repeat (steps[i]) @(posedge clk);
      #1;
      checks++;
      if (obs_s !== expv[i]) begin
        errors++;
        $display("FAIL vsync_row%0d: got x=%0d y=%0d hs/vs/on/ls/fs=%b, expected x=%0d y=%0d hs/vs/on/ls/fs=%b",
                 i, obs_s[26:16], obs_s[15:5], obs_s[4:0], expv[i][26:16], expv[i][15:5], expv[i][4:0]);
      end
    end
  endtask

  // From (0,0) on the small timing, one full frame is 32*19 = 608 ticks.
  task automatic test_full_frame();
    int          fs_cnt = 0;
    int          ls_cnt = 0;
    logic [26:0] exp;
    vga_s.pix_en = 1'b1;
    for (int i = 0; i < 608; i++) begin
      @(posedge clk);
      #1;
      if (vga_s.frame_start === 1'b1) fs_cnt++;
      if (vga_s.line_start === 1'b1) ls_cnt++;
    end
    vga_s.pix_en = 1'b0;
    checks++;
    if (fs_cnt !== 1) begin
      errors++;
      $display("FAIL frame_start_count: got %0d, expected 1", fs_cnt);
    end
    checks++;
    if (ls_cnt !== 19) begin
      errors++;
      $display("FAIL line_start_count: got %0d, expected 19", ls_cnt);
    end
    exp = {11'd0, 11'd0, 5'b11111};
    checks++;
    if (obs_s !== exp) begin
      errors++;
      $display("FAIL frame_return: got x=%0d y=%0d hs/vs/on/ls/fs=%b, expected x=%0d y=%0d hs/vs/on/ls/fs=%b",
               obs_s[26:16], obs_s[15:5], obs_s[4:0], exp[26:16], exp[15:5], exp[4:0]);
    end
  endtask
`else
  // pix_en tied low; ticks come from the internal toggle every 2nd clk.
  task automatic test_div2();
    logic [26:0] expv [6] = '{{11'd799, 11'd524, 5'b11000},
                              {11'd0,   11'd0,   5'b11111},
                              {11'd0,   11'd0,   5'b11100},
                              {11'd1,   11'd0,   5'b11100},
                              {11'd1,   11'd0,   5'b11100},
                              {11'd2,   11'd0,   5'b11100}};
    vga_m.pix_en = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs_m !== expv[i]) begin
        errors++;
        $display("FAIL div2_clk%0d: got x=%0d y=%0d hs/vs/on/ls/fs=%b, expected x=%0d y=%0d hs/vs/on/ls/fs=%b",
                 i + 1, obs_m[26:16], obs_m[15:5], obs_m[4:0], expv[i][26:16], expv[i][15:5], expv[i][4:0]);
      end
    end
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    reset_s      = 1'b1;
    vga_m.pix_en = 1'b0;
    vga_s.pix_en = 1'b0;
    test_reset();
`ifndef VGA_PIX_DIV2_EN
    test_first_tick();
    test_hsync();
    test_line_wrap();
    test_freeze();
    test_reset_mid_frame();
    test_vsync_small();
    test_full_frame();
`else
    test_div2();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates the pixel-coordinate stream and VGA sync signals that the downstream pixel/character memory consumes.
- Produces Posx/Posy counters, active-low hsync/vsync, a video_on qualifier and line/frame start strobes for 640x480@60 timing (800x525 total).
- Sits between the clock divider and the pixel memory/colour path in the display top level.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CNT_W, 11, width of the Posx/Posy counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  reset, synchronous, active-high
- pix_en  in  1  pixel tick enable, one clk wide, from the external divider
- posx  out  CNT_W  current horizontal position, 0..H_TOTAL-1
- posy  out  CNT_W  current vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high when posx<H_ACTIVE and posy<V_ACTIVE
- line_start  out  1  one-clk strobe when posx becomes 0
- frame_start  out  1  one-clk strobe when (posx,posy) becomes (0,0)

Behaviour:
- Derived values: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset state: posx=H_TOTAL-1 (799), posy=V_TOTAL-1 (524), hsync=1, vsync=1, video_on=0, line_start=0, frame_start=0.
  - This is a back-porch position, so all outputs are self-consistent.
  - The first tick after reset lands on (0,0).
- All outputs are registered. hsync, vsync and video_on are decoded from the next counter values, so on every cycle they match the posx/posy presented on that cycle. There is no extra pipeline stage.
- Tick behaviour: on a clk edge with tick=1, posx increments.
  - At posx=H_TOTAL-1, posx wraps to 0 and posy increments.
  - At posy=V_TOTAL-1 with posx wrapping, posy wraps to 0.
  - With tick=0, counters, hsync, vsync and video_on hold.
- hsync=0 iff H_ACTIVE+H_FP <= posx <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
- vsync=0 iff V_ACTIVE+V_FP <= posy <= V_ACTIVE+V_FP+V_SYNC-1 (490..491).
- line_start=1 for exactly one clk, on the edge where posx becomes 0. frame_start additionally requires posy becoming 0. Both clear on the next clk regardless of pix_en.
- pix_en held high continuously is legal: one pixel per clk.
- Reset asserted mid-frame: the reset state loads on that edge; reset takes priority over tick.
- Counter arithmetic is unsigned CNT_W bits. CNT_W must hold H_TOTAL-1 and V_TOTAL-1; no other overflow is possible.

Optional Feature:
- Macro: VGA_PIX_DIV2_EN
- Defined:
  - An internal toggle flop (reset to 0, flips every clk) supplies the tick, with tick = toggle==1.
  - pix_en is ignored; the port stays present.
  - The first tick occurs on the 2nd clk edge after reset deasserts.
- Undefined: tick = pix_en.

Decomposition:
- Package vga_timing_pkg holds:
  - timing constants (default porch/sync/active values, H_TOTAL, V_TOTAL)
  - CNT_W
  - a coord_t typedef of CNT_W bits
- One sub-module, vga_axis_counter, instantiated twice (horizontal and vertical):
  - parameterised wrap counter with enable
  - wrap flag output
  - sync-window and active-window decode

Test Plan:
- Reset for 3 clks -> posx=799, posy=524, hsync=1, vsync=1, video_on=0, strobes=0; first pix_en -> posx=0, posy=0, video_on=1, line_start=1, frame_start=1 for one clk.
- pix_en continuous, posx 655->656 -> hsync falls; posx 751->752 -> hsync rises; posx 639->640 -> video_on falls.
- Line wrap at posx=799, posy=10 -> posx=0, posy=11, line_start=1, frame_start=0; posy 489->490 -> vsync=0; 491->492 -> vsync=1.
- Run 800*525 ticks from (0,0) -> returns to (0,0) with frame_start exactly once per frame; pix_en low for 5 clks mid-line -> all outputs frozen.
- Reset asserted at (300,200) together with pix_en -> reset state next edge, no strobe.
- VGA_PIX_DIV2_EN defined, pix_en tied 0 -> posx advances every 2nd clk; (0,0) reached on 2nd clk after reset release.
